// File: rtl/timer_multi.sv
// timer_multi: multi-channel memory-mapped timer on the simple-system device bus.
//
// One shared 64-bit prescaled time base (mtime) and NrChannels independent 64-bit
// comparators, each one-shot or periodic with auto-reload. Per-channel and
// aggregated interrupt outputs are registered.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   timer_req_i        bus request (always granted, one access per cycle)
//   timer_we_i         write enable
//   timer_be_i         byte enables
//   timer_addr_i       byte address, bits [9:2] decoded
//   timer_wdata_i      write data
//   timer_rvalid_o     response valid, one cycle after req
//   timer_rdata_o      read data (0 on writes and errors)
//   timer_err_o        error response (unmapped offset / absent channel)
//   timer_intr_o       |(IRQ_STATUS & IRQ_ENABLE), registered
//   timer_ch_intr_o    IRQ_STATUS & IRQ_ENABLE per channel, registered
//
// Optional build macro: TIMER_MULTI_SNAPSHOT_EN
//   When defined, a read of MTIME_LO / CMPn_LO captures the upper word into a
//   shadow that the next MTIME_HI / CMPn_HI read returns (tear-free 64-bit read).
//
// Only DataWidth = 32 is supported.
module timer_multi #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned NrChannels     = 4,
  parameter int unsigned PrescalerWidth = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      timer_req_i,
  input  logic                      timer_we_i,
  input  logic [DataWidth/8-1:0]    timer_be_i,
  input  logic [AddressWidth-1:0]   timer_addr_i,
  input  logic [DataWidth-1:0]      timer_wdata_i,
  output logic                      timer_rvalid_o,
  output logic [DataWidth-1:0]      timer_rdata_o,
  output logic                      timer_err_o,
  output logic                      timer_intr_o,
  output logic [NrChannels-1:0]     timer_ch_intr_o
);

  // State
  logic [63:0]               mtime_q, mtime_d;
  logic [PrescalerWidth-1:0] prescale_q, prescale_d;
  logic [PrescalerWidth-1:0] presc_cnt_q, presc_cnt_d;
  logic                      ctrl_en_q, ctrl_en_d;
  logic [NrChannels-1:0]     irq_status_q, irq_status_d;
  logic [NrChannels-1:0]     irq_enable_q, irq_enable_d;
  logic [63:0]               cmp_q [NrChannels];
  logic [63:0]               cmp_d [NrChannels];
  logic [31:0]               period_q [NrChannels];
  logic [31:0]               period_d [NrChannels];
  logic [NrChannels-1:0]     ch_en_q, ch_en_d;
  logic [NrChannels-1:0]     ch_per_q, ch_per_d;

  // Decode
  logic [7:0]            widx;
  logic                  is_ch;
  logic [5:0]            ch_raw;
  logic                  glob_sel;
  logic [NrChannels-1:0] ch_sel;
  logic                  hit;
  logic                  wr;
  logic                  rd;
  logic [31:0]           be_mask;
  logic [31:0]           wdata_masked;
  logic [31:0]           live_word;
  logic [31:0]           new_word;
  logic [31:0]           rd_word;
  logic                  tick;
  logic [NrChannels-1:0] match;

  logic unused_addr;
  assign unused_addr = ^{timer_addr_i[AddressWidth-1:10], timer_addr_i[1:0]};

  assign widx     = timer_addr_i[9:2];
  assign is_ch    = (widx[7:6] != 2'b00);
  // Channel block starts at word 0x40, four words per channel.
  assign ch_raw   = widx[7:2] - 6'd16;
  assign glob_sel = (widx[7:6] == 2'b00) && (widx[5:0] < 6'd6);

  always_comb begin
    ch_sel = '0;
    for (int n = 0; n < NrChannels; n++) begin
      ch_sel[n] = is_ch && (ch_raw == 6'(n));
    end
  end

  assign hit = glob_sel | (|ch_sel);
  assign wr  = timer_req_i & timer_we_i & hit;
  assign rd  = timer_req_i & ~timer_we_i & hit;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      be_mask[8*i +: 8] = {8{timer_be_i[i]}};
    end
  end

  assign wdata_masked = timer_wdata_i & be_mask;

  // Live (non-shadow) value of the addressed word; also the base for byte-enable merges.
  always_comb begin
    live_word = '0;
    if (glob_sel) begin
      case (widx[2:0])
        3'd0:    live_word = mtime_q[31:0];
        3'd1:    live_word = mtime_q[63:32];
        3'd2:    live_word = 32'(prescale_q);
        3'd3:    live_word = {31'b0, ctrl_en_q};
        3'd4:    live_word = 32'(irq_status_q);
        3'd5:    live_word = 32'(irq_enable_q);
        default: live_word = '0;
      endcase
    end
    for (int n = 0; n < NrChannels; n++) begin
      if (ch_sel[n]) begin
        case (widx[1:0])
          2'd0:    live_word = cmp_q[n][31:0];
          2'd1:    live_word = cmp_q[n][63:32];
          2'd2:    live_word = {30'b0, ch_per_q[n], ch_en_q[n]};
          default: live_word = period_q[n];
        endcase
      end
    end
  end

  assign new_word = (live_word & ~be_mask) | wdata_masked;

`ifdef TIMER_MULTI_SNAPSHOT_EN
  logic [31:0] mtime_shadow_q;
  logic [31:0] cmp_shadow_q [NrChannels];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_shadow_q <= '0;
      for (int n = 0; n < NrChannels; n++) cmp_shadow_q[n] <= '0;
    end else begin
      if (rd && glob_sel && (widx[2:0] == 3'd0)) mtime_shadow_q <= mtime_q[63:32];
      for (int n = 0; n < NrChannels; n++) begin
        if (rd && ch_sel[n] && (widx[1:0] == 2'd0)) cmp_shadow_q[n] <= cmp_q[n][63:32];
      end
    end
  end

  always_comb begin
    rd_word = live_word;
    if (glob_sel && (widx[2:0] == 3'd1)) rd_word = mtime_shadow_q;
    for (int n = 0; n < NrChannels; n++) begin
      if (ch_sel[n] && (widx[1:0] == 2'd1)) rd_word = cmp_shadow_q[n];
    end
  end
`else
  assign rd_word = live_word;
`endif

  // Prescaler and time base
  always_comb begin
    tick        = 1'b0;
    presc_cnt_d = presc_cnt_q;
    if (ctrl_en_q) begin
      if (presc_cnt_q == prescale_q) begin
        tick        = 1'b1;
        presc_cnt_d = '0;
      end else if (presc_cnt_q > prescale_q) begin
        // PRESCALE was lowered below the running count: restart without a tick.
        presc_cnt_d = '0;
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end
    end

    // A software write to either half suppresses the increment for that cycle.
    if (wr && glob_sel && (widx[2:0] == 3'd0)) begin
      mtime_d = {mtime_q[63:32], new_word};
    end else if (wr && glob_sel && (widx[2:0] == 3'd1)) begin
      mtime_d = {new_word, mtime_q[31:0]};
    end else begin
      mtime_d = mtime_q + 64'(tick);
    end

    prescale_d   = prescale_q;
    ctrl_en_d    = ctrl_en_q;
    irq_enable_d = irq_enable_q;
    irq_status_d = irq_status_q;
    if (wr && glob_sel) begin
      case (widx[2:0])
        3'd2:    prescale_d   = new_word[PrescalerWidth-1:0];
        3'd3:    ctrl_en_d    = new_word[0];
        3'd4:    irq_status_d = irq_status_q & ~wdata_masked[NrChannels-1:0];
        3'd5:    irq_enable_d = new_word[NrChannels-1:0];
        default: ;
      endcase
    end
    // Hardware set wins over a simultaneous W1C.
    irq_status_d = irq_status_d | match;
  end

  // Channels
  always_comb begin
    ch_en_d  = ch_en_q;
    ch_per_d = ch_per_q;
    match    = '0;
    for (int n = 0; n < NrChannels; n++) begin
      cmp_d[n]    = cmp_q[n];
      period_d[n] = period_q[n];
      match[n]    = ch_en_q[n] && (mtime_q >= cmp_q[n]);
      // A software write to CMP or CH_CTRL overrides the automatic update.
      if (match[n] && !(wr && ch_sel[n] && (widx[1:0] != 2'd3))) begin
        if (ch_per_q[n]) cmp_d[n] = cmp_q[n] + 64'(period_q[n]);
        else             ch_en_d[n] = 1'b0;
      end
      if (wr && ch_sel[n]) begin
        case (widx[1:0])
          2'd0: cmp_d[n][31:0]  = new_word;
          2'd1: cmp_d[n][63:32] = new_word;
          2'd2: begin
            ch_en_d[n]  = new_word[0];
            ch_per_d[n] = new_word[1];
          end
          default: period_d[n] = new_word;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q      <= '0;
      prescale_q   <= '0;
      presc_cnt_q  <= '0;
      ctrl_en_q    <= 1'b0;
      irq_status_q <= '0;
      irq_enable_q <= '0;
      ch_en_q      <= '0;
      ch_per_q     <= '0;
      for (int n = 0; n < NrChannels; n++) begin
        cmp_q[n]    <= '1;
        period_q[n] <= '0;
      end
    end else begin
      mtime_q      <= mtime_d;
      prescale_q   <= prescale_d;
      presc_cnt_q  <= presc_cnt_d;
      ctrl_en_q    <= ctrl_en_d;
      irq_status_q <= irq_status_d;
      irq_enable_q <= irq_enable_d;
      ch_en_q      <= ch_en_d;
      ch_per_q     <= ch_per_d;
      for (int n = 0; n < NrChannels; n++) begin
        cmp_q[n]    <= cmp_d[n];
        period_q[n] <= period_d[n];
      end
    end
  end

  // Bus response and interrupt outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_rvalid_o  <= 1'b0;
      timer_rdata_o   <= '0;
      timer_err_o     <= 1'b0;
      timer_intr_o    <= 1'b0;
      timer_ch_intr_o <= '0;
    end else begin
      timer_rvalid_o  <= timer_req_i;
      timer_err_o     <= timer_req_i & ~hit;
      timer_rdata_o   <= rd ? rd_word : '0;
      timer_intr_o    <= |(irq_status_q & irq_enable_q);
      timer_ch_intr_o <= irq_status_q & irq_enable_q;
    end
  end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: table-driven register vectors plus directed
// multi-cycle sequences (prescaler, one-shot, periodic, error decode, split 64-bit
// read, reset during an access).
module tb_timer_multi;

  localparam int unsigned NrCh = 4;
`ifdef TIMER_MULTI_SNAPSHOT_EN
  localparam bit Snapshot = 1'b1;
`else
  localparam bit Snapshot = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            timer_req_i = 1'b0;
  logic            timer_we_i = 1'b0;
  logic [3:0]      timer_be_i = 4'h0;
  logic [31:0]     timer_addr_i = '0;
  logic [31:0]     timer_wdata_i = '0;
  logic            timer_rvalid_o;
  logic [31:0]     timer_rdata_o;
  logic            timer_err_o;
  logic            timer_intr_o;
  logic [NrCh-1:0] timer_ch_intr_o;

  timer_multi #(
    .DataWidth(32),
    .AddressWidth(32),
    .NrChannels(NrCh),
    .PrescalerWidth(8)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .timer_req_i(timer_req_i),
    .timer_we_i(timer_we_i),
    .timer_be_i(timer_be_i),
    .timer_addr_i(timer_addr_i),
    .timer_wdata_i(timer_wdata_i),
    .timer_rvalid_o(timer_rvalid_o),
    .timer_rdata_o(timer_rdata_o),
    .timer_err_o(timer_err_o),
    .timer_intr_o(timer_intr_o),
    .timer_ch_intr_o(timer_ch_intr_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one access, returns at the next negedge with the response.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output logic rv);
    timer_req_i   = 1'b1;
    timer_we_i    = we;
    timer_addr_i  = addr;
    timer_wdata_i = wdata;
    timer_be_i    = be;
    @(negedge clk_i);
    rv            = timer_rvalid_o;
    rdata         = timer_rdata_o;
    err           = timer_err_o;
    timer_req_i   = 1'b0;
    timer_we_i    = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    logic e, v;
    bus(1'b1, addr, data, 4'hF, r, e, v);
    check($sformatf("wr 0x%0h rvalid", addr), 64'(v), 64'd1);
    check($sformatf("wr 0x%0h err", addr), 64'(e), 64'd0);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic e, v;
    bus(1'b0, addr, 32'h0, 4'hF, data, e, v);
    check($sformatf("rd 0x%0h rvalid", addr), 64'(v), 64'd1);
    check($sformatf("rd 0x%0h err", addr), 64'(e), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, lo, hi;
    logic        e, v;
    int          waited;
    logic [63:0] val, nxt, exp_hi;

    vecs.push_back('{1'b0, 32'h000, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h004, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h100, 32'h0,        4'hF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 32'h104, 32'h0,        4'hF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 32'h108, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10C, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h00C, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h008, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h008, 32'h12345603, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h008, 32'h0,        4'hF, 32'h03,       1'b0});
    vecs.push_back('{1'b1, 32'h008, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h014, 32'hFFFFFFFF, 4'h1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h014, 32'h0,        4'hF, 32'h0F,       1'b0});
    vecs.push_back('{1'b1, 32'h014, 32'h0,        4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h014, 32'h0,        4'hF, 32'h0F,       1'b0});
    vecs.push_back('{1'b1, 32'h014, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h014, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h10C, 32'hAABBCCDD, 4'h6, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10C, 32'h0,        4'hF, 32'h00BBCC00, 1'b0});
    vecs.push_back('{1'b1, 32'h108, 32'hFF,       4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h108, 32'h0,        4'hF, 32'h3,        1'b0});
    vecs.push_back('{1'b1, 32'h108, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h0F0, 32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h140, 32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h140, 32'h1234,     4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h14C, 32'h5555,     4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h0F0, 32'h1,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h018, 32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h130, 32'h0,        4'hF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 32'h134, 32'h0,        4'hF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b1, 32'h10C, 32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10C, 32'h0,        4'hF, 32'h0,        1'b0});

    // Reset state
    repeat (3) @(negedge clk_i);
    check("reset rvalid", 64'(timer_rvalid_o), 64'd0);
    check("reset rdata", 64'(timer_rdata_o), 64'd0);
    check("reset err", 64'(timer_err_o), 64'd0);
    check("reset intr", 64'(timer_intr_o), 64'd0);
    check("reset ch_intr", 64'(timer_ch_intr_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Back-to-back register vectors
    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, r, e, v);
      check($sformatf("vec%0d rvalid", i), 64'(v), 64'd1);
      check($sformatf("vec%0d rdata", i), 64'(r), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d err", i), 64'(e), 64'(vecs[i].exp_err));
    end
    @(negedge clk_i);
    check("idle rvalid", 64'(timer_rvalid_o), 64'd0);

    // Prescaler: PRESCALE=3 for 40 enabled cycles gives 10 ticks, then held
    wr(32'h008, 32'd3);
    wr(32'h00C, 32'd1);
    repeat (39) @(negedge clk_i);
    wr(32'h00C, 32'd0);
    rd(32'h000, r);
    check("prescale mtime", 64'(r), 64'd10);
    repeat (5) @(negedge clk_i);
    rd(32'h000, r);
    check("prescale mtime held", 64'(r), 64'd10);

    // Channel 0 one-shot at mtime 5
    wr(32'h000, 32'd0);
    wr(32'h004, 32'd0);
    wr(32'h008, 32'd0);
    wr(32'h100, 32'd5);
    wr(32'h104, 32'd0);
    wr(32'h014, 32'd1);
    wr(32'h108, 32'd1);
    wr(32'h00C, 32'd1);
    waited = 0;
    while (!timer_ch_intr_o[0] && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    check("oneshot latency", 64'(waited), 64'd7);
    check("oneshot intr", 64'(timer_intr_o), 64'd1);
    rd(32'h108, r);
    check("oneshot en cleared", 64'(r), 64'd0);
    wr(32'h010, 32'd1);
    @(negedge clk_i);
    check("oneshot w1c ch_intr", 64'(timer_ch_intr_o[0]), 64'd0);
    check("oneshot w1c intr", 64'(timer_intr_o), 64'd0);

    // Channel 1 periodic: matches at mtime 10, 20, 30
    wr(32'h00C, 32'd0);
    wr(32'h000, 32'd0);
    wr(32'h004, 32'd0);
    wr(32'h110, 32'd10);
    wr(32'h114, 32'd0);
    wr(32'h11C, 32'd10);
    wr(32'h014, 32'd2);
    wr(32'h118, 32'd3);
    wr(32'h00C, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      waited = 0;
      while (!timer_ch_intr_o[1] && waited < 60) begin
        @(negedge clk_i);
        waited++;
      end
      check($sformatf("periodic%0d seen", k), 64'(timer_ch_intr_o[1]), 64'd1);
      rd(32'h000, r);
      check($sformatf("periodic%0d mtime", k), 64'(r), 64'(10 * k + 2));
      rd(32'h110, r);
      check($sformatf("periodic%0d cmp", k), 64'(r), 64'(10 * (k + 1)));
      wr(32'h010, 32'd2);
      @(negedge clk_i);
      check($sformatf("periodic%0d cleared", k), 64'(timer_ch_intr_o[1]), 64'd0);
    end
    wr(32'h118, 32'd0);

    // Errored writes left channel 1 and IRQ_ENABLE alone
    bus(1'b1, 32'h15C, 32'h77, 4'hF, r, e, v);
    check("err write ch5 err", 64'(e), 64'd1);
    rd(32'h11C, r);
    check("period1 intact", 64'(r), 64'd10);
    rd(32'h014, r);
    check("irq_enable intact", 64'(r), 64'd2);

    // Split 64-bit read across the low-word carry
    wr(32'h00C, 32'd0);
    wr(32'h000, 32'hFFFFFFF1);
    wr(32'h004, 32'd0);
    wr(32'h00C, 32'd1);
    for (int j = 0; j < 10; j++) begin
      bus(1'b0, 32'h000, 32'h0, 4'hF, lo, e, v);
      bus(1'b0, 32'h004, 32'h0, 4'hF, hi, e, v);
      val = 64'hFFFFFFF1 + 64'(2 * j);
      nxt = val + 64'd1;
      exp_hi = Snapshot ? (val >> 32) : (nxt >> 32);
      check($sformatf("split%0d lo", j), 64'(lo), val & 64'hFFFFFFFF);
      check($sformatf("split%0d hi", j), 64'(hi), exp_hi);
    end

    // Reset during an access: no response for it
    timer_req_i  = 1'b1;
    timer_addr_i = 32'h000;
    #3 rst_ni = 1'b0;
    #4 timer_req_i = 1'b0;
    @(negedge clk_i);
    check("abort rvalid", 64'(timer_rvalid_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    rd(32'h000, r);
    check("post-reset mtime", 64'(r), 64'd0);
    rd(32'h11C, r);
    check("post-reset period1", 64'(r), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
